eth_pkt_gen: RTL and testbench
==============================

# eth_pkt_gen

Packet source that drives one ingress port of the Ethernet switch. It accepts a packet command (destination, source, payload length) and emits a framed packet on a 32-bit data/start/end interface. Each packet carries a header, a counting-pattern payload and an XOR checksum trailer. It honours the switch's per-port stall signal at packet boundaries, and is used both as a bench stimulus source and as an on-chip loopback/self-test traffic generator.

## Interface

- MAX_LEN, 64, maximum payload words per packet (1..255)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  packet command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready
- cmd_dst  in  32  destination word (packet word 0)
- cmd_src  in  32  source word (packet word 1)
- cmd_len  in  8  payload length in words (0 allowed)
- i_stall  in  1  port backpressure from switch; connects to the port's stall output
- o_data  out  32  packet data word
- o_start  out  1  high on first word of packet
- o_end  out  1  high on last word of packet
- busy  out  1  packet in flight (state != IDLE)
- pkt_count  out  16  completed packets (o_end words emitted), wraps

## Operation

- Packet format, len = min(cmd_len, MAX_LEN), N = len+4 words, contiguous (no gaps):
  - w0 = cmd_dst (o_start=1)
  - w1 = cmd_src
  - w2 = {len[15:0] zero-extended, seq[15:0]}
  - w3..w(2+len): payload word i (0-based) = {seq, i[15:0]}
  - w(N-1) = XOR of w0..w(N-2) (o_end=1)
- FSM states: IDLE, DST, SRC, LEN, PAY, CSUM. The state names the word currently on the outputs.
  - IDLE -> DST on accept; cmd_dst, cmd_src, len and seq are latched at accept.
  - DST -> SRC -> LEN unconditionally.
  - LEN -> PAY if len>0, else CSUM.
  - PAY -> PAY while index < len-1, else CSUM.
  - CSUM -> IDLE.
- cmd_ready = (state==IDLE) && !i_stall && !rst; combinational.
- i_stall is sampled only in IDLE. Once a packet starts it streams to completion regardless of i_stall.
- Checksum accumulator: cleared on accept, XORs each emitted word w0..w(N-2).
- seq: 16-bit counter, 0 after reset, used for the accepted packet then incremented at accept; wraps 0xFFFF -> 0x0000.
- cmd_len > MAX_LEN saturates to MAX_LEN, both in the length field and in the payload count.
- pkt_count increments on each cycle with o_end=1; wraps.

## Timing

- All outputs except cmd_ready are registered.
- Reset values: o_data=0, o_start=0, o_end=0, busy=0, pkt_count=0, seq=0, state IDLE. cmd_ready=0 while rst=1.
- In IDLE: o_data=0, o_start=0, o_end=0.
- Latency: accept at edge k -> w0 with o_start visible in cycle k+1; o_end in cycle k+N.
- o_start and o_end never assert in the same cycle (minimum N=4).
- Back-to-back: at least one IDLE cycle between o_end and the next o_start. With cmd_valid held and i_stall low, the gap is exactly one cycle.
- Reset mid-packet: at the next edge state is IDLE and all outputs are zero. The truncated packet emits no o_end and pkt_count does not increment. seq restarts at 0.
- cmd_* inputs are don't-care outside the accept cycle.

## Test plan

- After reset, issue cmd dst=0x00000001, src=0xA5A50002, len=2 -> 6 words: 0x00000001 (start), 0xA5A50002, 0x00020000, 0x00000000, 0x00000001, 0xA5A70002 (end). pkt_count=1.
- len=0, dst=0x11111111, src=0x22222222, second packet after reset (seq=1) -> 4 words, last = 0x33333333 ^ 0x00000001 = 0x33333332 with o_end. o_start and o_end in separate cycles.
- i_stall=1 with cmd_valid=1 for 5 cycles -> cmd_ready=0, outputs zero. Drop i_stall -> accept that cycle, o_start the next cycle. Then raise i_stall during payload -> packet still completes contiguously.
- Three back-to-back cmds, len=1 -> exactly one idle cycle between each o_end and the next o_start. w2 seq fields are 0, 1, 2. pkt_count=3.
- rst pulsed during PAY of a len=8 packet -> next cycle all outputs 0, no o_end. The following packet has seq=0 and pkt_count counts from 0.
- MAX_LEN=64, cmd_len=200 -> 68 words, w2=0x00400000. Payload indices run 0..63 and the checksum matches the XOR of the first 67 words.

Source files
------------

// File: rtl/eth_pkt_gen.sv
// Framed packet source for one switch ingress port: dst/src/len header, counting payload,
// XOR trailer. Stall is honoured only between packets.
module eth_pkt_gen #(
    parameter int MAX_LEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_dst,
    input  logic [31:0] cmd_src,
    input  logic [7:0]  cmd_len,
    input  logic        i_stall,
    output logic [31:0] o_data,
    output logic        o_start,
    output logic        o_end,
    output logic        busy,
    output logic [15:0] pkt_count
);
    localparam logic [7:0] MAX_LEN_W = 8'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, DST, SRC, LEN, PAY, CSUM} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] src_q;
    logic [31:0] csum_q;
    logic [31:0] data_nxt;
    logic [7:0]  len_q;
    logic [7:0]  idx_q;
    logic [7:0]  idx_nxt;
    logic [15:0] seq;
    logic [15:0] pkt_seq;
    logic        accept;
    logic        start_nxt;
    logic        end_nxt;

    function automatic logic [7:0] sat_len(input logic [7:0] len);
        return (len > MAX_LEN_W) ? MAX_LEN_W : len;
    endfunction

    assign cmd_ready = (state == IDLE) && !i_stall && !rst;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DST;
            DST:     state_nxt = SRC;
            SRC:     state_nxt = LEN;
            LEN:     state_nxt = (len_q != 8'd0) ? PAY : CSUM;
            PAY:     state_nxt = (idx_q < len_q - 8'd1) ? PAY : CSUM;
            CSUM:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next-word decode: outputs are registered, so this selects the word for state_nxt.
    always_comb begin
        idx_nxt   = (state == PAY) ? idx_q + 8'd1 : 8'd0;
        data_nxt  = '0;
        start_nxt = 1'b0;
        end_nxt   = 1'b0;
        case (state_nxt)
            DST: begin
                data_nxt  = cmd_dst;
                start_nxt = 1'b1;
            end
            SRC:  data_nxt = src_q;
            LEN:  data_nxt = {8'h00, len_q, pkt_seq};
            PAY:  data_nxt = {pkt_seq, 8'h00, idx_nxt};
            CSUM: begin
                data_nxt = csum_q ^ o_data;
                end_nxt  = 1'b1;
            end
            default: data_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data    <= '0;
            o_start   <= 1'b0;
            o_end     <= 1'b0;
            busy      <= 1'b0;
            pkt_count <= '0;
            seq       <= '0;
        end else begin
            o_data    <= data_nxt;
            o_start   <= start_nxt;
            o_end     <= end_nxt;
            busy      <= (state_nxt != IDLE);
            pkt_count <= pkt_count + {15'd0, o_end};
            if (accept) seq <= seq + 16'd1;
        end
    end

    // Per-packet context; the accumulator folds in each word while it is on the outputs.
    always_ff @(posedge clk) begin
        if (accept) begin
            src_q   <= cmd_src;
            len_q   <= sat_len(cmd_len);
            pkt_seq <= seq;
            csum_q  <= '0;
        end else if (state inside {DST, SRC, LEN, PAY}) begin
            csum_q  <= csum_q ^ o_data;
        end
        idx_q <= idx_nxt;
    end

endmodule

// File: tb/tb_eth_pkt_gen.sv
// Directed-vector bench for eth_pkt_gen: packet table plus stall, back-to-back,
// mid-packet reset and length-saturation sequences.
module tb_eth_pkt_gen;
    localparam int MAX_LEN = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_dst;
    logic [31:0] cmd_src;
    logic [7:0]  cmd_len;
    logic        i_stall;
    logic [31:0] o_data;
    logic        o_start;
    logic        o_end;
    logic        busy;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    eth_pkt_gen #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_len(cmd_len), .i_stall(i_stall),
        .o_data(o_data), .o_start(o_start), .o_end(o_end), .busy(busy),
        .pkt_count(pkt_count)
    );

    typedef struct {
        logic [31:0] dst;
        logic [31:0] src;
        logic [7:0]  len;
        int          exp_len;
        logic [15:0] exp_seq;
        logic [31:0] exp_csum;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t        tbl [4];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] wbuf [0:299];
    int          wcnt;
    logic        frame_ok;
    int          start_cyc [4];
    int          end_cyc [4];
    logic [15:0] seqf [4];
    int          ns;
    int          ne;
    int          stray_end;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns just after the accepting posedge with cmd_valid dropped.
    task automatic issue(input logic [31:0] d, input logic [31:0] s, input logic [7:0] l);
        int t = 0;
        cmd_dst = d; cmd_src = s; cmd_len = l; cmd_valid = 1'b1;
        #1;
        while (!cmd_ready && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        check("accept_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic collect();
        int  t = 0;
        logic done = 1'b0;
        wcnt = 0;
        frame_ok = 1'b1;
        while (!done && t < 300) begin
            @(negedge clk);
            if (busy !== 1'b1) frame_ok = 1'b0;
            if (o_start !== (wcnt == 0)) frame_ok = 1'b0;
            wbuf[wcnt] = o_data;
            wcnt++;
            done = o_end;
            t++;
        end
        check("collect_end_seen", 32'(done), 32'd1);
    endtask

    task automatic check_pkt(input logic [31:0] d, input logic [31:0] s, input int elen,
                             input logic [15:0] sq, input logic [31:0] csum, input logic [15:0] cnt);
        int bad = 0;
        check("frame_contiguous", 32'(frame_ok), 32'd1);
        check("word_count", 32'(wcnt), 32'(elen + 4));
        check("w0_dst", wbuf[0], d);
        check("w1_src", wbuf[1], s);
        check("w2_len_seq", wbuf[2], {8'h00, 8'(elen), sq});
        for (int i = 0; i < elen; i++)
            if (wbuf[3 + i] !== {sq, 16'(i)}) bad++;
        check("payload_words_bad", 32'(bad), 32'd0);
        check("csum_word", wbuf[elen + 3], csum);
        @(negedge clk);
        check("pkt_count", 32'(pkt_count), 32'(cnt));
        check("idle_after_end", 32'({busy, o_start, o_end}), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; i_stall = 1'b0;
        cmd_dst = '0; cmd_src = '0; cmd_len = '0;

        tbl[0] = '{32'h0000_0001, 32'hA5A5_0002, 8'd2, 2, 16'd0, 32'hA5A7_0002, 16'd1};
        tbl[1] = '{32'h1111_1111, 32'h2222_2222, 8'd0, 0, 16'd1, 32'h3333_3332, 16'd2};
        tbl[2] = '{32'hDEAD_BEEF, 32'h0000_0000, 8'd1, 1, 16'd2, 32'hDEAE_BEED, 16'd3};
        tbl[3] = '{32'hFFFF_FFFF, 32'h1234_5678, 8'd3, 3, 16'd3, 32'hEDCB_A987, 16'd4};

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_o_data", o_data, 32'd0);
        check("rst_flags", 32'({o_start, o_end, busy}), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            issue(tbl[v].dst, tbl[v].src, tbl[v].len);
            collect();
            check_pkt(tbl[v].dst, tbl[v].src, tbl[v].exp_len, tbl[v].exp_seq,
                      tbl[v].exp_csum, tbl[v].exp_cnt);
        end

        // Stall held in IDLE blocks accept; stall raised mid-packet is ignored.
        i_stall = 1'b1;
        cmd_dst = 32'h0A0A_0A0A; cmd_src = 32'h0B0B_0B0B; cmd_len = 8'd4; cmd_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check("stall_o_data", o_data, 32'd0);
            check("stall_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        i_stall = 1'b0;
        #1;
        check("unstall_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        i_stall = 1'b1;
        collect();
        check_pkt(32'h0A0A_0A0A, 32'h0B0B_0B0B, 4, 16'd4, 32'h0105_0105, 16'd5);
        #1;
        check("stall_idle_ready", 32'(cmd_ready), 32'd0);
        i_stall = 1'b0;

        // Oversized length saturates to MAX_LEN.
        do_reset();
        issue(32'hCAFE_F00D, 32'h0123_4567, 8'd200);
        collect();
        check_pkt(32'hCAFE_F00D, 32'h0123_4567, 64, 16'd0, 32'hCB9D_B56A, 16'd1);

        // Back-to-back with cmd_valid held: one idle cycle between packets.
        do_reset();
        cmd_dst = 32'h0000_00AA; cmd_src = 32'h0000_00BB; cmd_len = 8'd1; cmd_valid = 1'b1;
        ns = 0; ne = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_start && ns < 4) begin
                start_cyc[ns] = c;
                ns++;
                if (ns == 3) cmd_valid = 1'b0;
            end
            if (ns > 0 && ns <= 4 && c == start_cyc[ns - 1] + 2) seqf[ns - 1] = o_data[15:0];
            if (o_end && ne < 4) begin
                end_cyc[ne] = c;
                ne++;
            end
        end
        cmd_valid = 1'b0;
        check("b2b_starts", 32'(ns), 32'd3);
        check("b2b_ends", 32'(ne), 32'd3);
        check("b2b_pkt_len", 32'(end_cyc[0] - start_cyc[0]), 32'd4);
        check("b2b_gap0", 32'(start_cyc[1] - end_cyc[0]), 32'd2);
        check("b2b_gap1", 32'(start_cyc[2] - end_cyc[1]), 32'd2);
        check("b2b_seq0", 32'(seqf[0]), 32'd0);
        check("b2b_seq1", 32'(seqf[1]), 32'd1);
        check("b2b_seq2", 32'(seqf[2]), 32'd2);
        check("b2b_pkt_count", 32'(pkt_count), 32'd3);

        // Reset during payload truncates the packet and restarts seq/pkt_count.
        issue(32'h0000_0001, 32'h0000_0002, 8'd8);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_o_data", o_data, 32'd0);
        check("midrst_flags", 32'({o_start, o_end, busy}), 32'd0);
        check("midrst_pkt_count", 32'(pkt_count), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        stray_end = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_end || busy) stray_end++;
        end
        check("midrst_no_tail", 32'(stray_end), 32'd0);
        issue(32'h0000_0005, 32'h0000_0006, 8'd0);
        collect();
        check_pkt(32'h0000_0005, 32'h0000_0006, 0, 16'd0, 32'h0000_0003, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
